julia_pixel_writer: RTL and testbench



---
 rtl/julia_pixel_writer.sv | 184 ++++++++++++++++++
 tb/tb_julia_pixel_writer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/julia_pixel_writer.sv
// julia_pixel_writer: maps Julia pixel results to colour and frame-buffer
// address, queues them in a small FIFO and drains them through an Avalon-MM
// write master. Signals frame completion after H_RES*V_RES writes.
// Optional build macro: JULIA_PIXWR_STALL_CNT_EN enables the stall_cycles
// counter; without it stall_cycles is tied to zero.
module julia_pixel_writer #(
  parameter int unsigned ADDRW     = 26,
  parameter logic [31:0] BASE_ADDR = 32'h0800_0000,
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned ITERW     = 8,
  parameter int unsigned MAX_ITER  = 255,
  parameter int unsigned DEPTH     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_frame,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [9:0]       pix_x,
  input  logic [8:0]       pix_y,
  input  logic [ITERW-1:0] pix_iter,
  output logic [ADDRW-1:0] master_address,
  output logic [31:0]      master_writedata,
  output logic             master_write,
  input  logic             master_waitrequest,
  output logic             busy,
  output logic             frame_done,
  output logic             err_oob,
  output logic [31:0]      stall_cycles
);

  localparam int unsigned PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW  = PTRW + 1;
  localparam int unsigned ENTW  = ADDRW + 32;
  localparam int unsigned DONEW = 19;
  localparam int unsigned FRAME = H_RES * V_RES;
  localparam logic [DONEW-1:0] FRAME_CNT = DONEW'(FRAME);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DONEW-1:0]  done_cnt_q, done_cnt_d;
  logic              err_oob_q, err_oob_d;
  logic              pix_ready_q, pix_ready_d;
  logic              master_write_q, master_write_d;
  logic [ENTW-1:0]   head_q, head_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic [ENTW-1:0]   mem [DEPTH];

  logic              accept, in_range, push, pop, start_clr;
  logic [31:0]       lin_idx, addr_full, iter_ext;
  logic [7:0]        gray;
  logic [31:0]       colour;
  logic [ENTW-1:0]   push_entry;
  logic [CNTW-1:0]   count_after_pop;

  // Pixel acceptance, address and colour mapping
  always_comb begin
    accept     = pix_valid && pix_ready_q;
    in_range   = (32'(pix_x) < H_RES) && (32'(pix_y) < V_RES);
    push       = accept && in_range;
    pop        = master_write_q && !master_waitrequest;
    start_clr  = (state_q == S_IDLE) && start_frame;
    lin_idx    = 32'(pix_y) * 32'(H_RES) + 32'(pix_x);
    addr_full  = BASE_ADDR + (lin_idx << 2);
    iter_ext   = 32'(pix_iter);
    gray       = iter_ext[7:0];
    colour     = (pix_iter == ITERW'(MAX_ITER)) ? 32'h0 : {8'h00, gray, gray, gray};
    push_entry = {addr_full[ADDRW-1:0], colour};
  end

  // FIFO bookkeeping, head prefetch and frame counters
  always_comb begin
    count_after_pop = count_q - CNTW'(pop);
    count_d         = count_after_pop + CNTW'(push);
    wr_ptr_d        = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
    rd_ptr_d        = pop  ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
    master_write_d  = (count_d != '0);
    // A push into an otherwise empty queue becomes the head directly
    if (count_after_pop == '0) begin
      head_d = push ? push_entry : head_q;
    end else begin
      head_d = mem[rd_ptr_d];
    end
    done_cnt_d = done_cnt_q;
    if (start_clr) begin
      done_cnt_d = '0;
    end else if (pop && (done_cnt_q != FRAME_CNT)) begin
      done_cnt_d = done_cnt_q + DONEW'(1);
    end
    err_oob_d = err_oob_q;
    if (start_clr) begin
      err_oob_d = 1'b0;
    end else if (accept && !in_range) begin
      err_oob_d = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_frame) state_d = S_RUN;
      S_RUN:  if (done_cnt_q == FRAME_CNT) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, computed from the upcoming state so the registers align with it
  always_comb begin
    busy_d       = (state_d == S_RUN);
    frame_done_d = (state_d == S_DONE);
    pix_ready_d  = (state_d == S_RUN) && (count_d != CNTW'(DEPTH));
  end

  // FIFO storage (no reset needed; validity tracked by count)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_entry;
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      done_cnt_q     <= '0;
      err_oob_q      <= 1'b0;
      pix_ready_q    <= 1'b0;
      master_write_q <= 1'b0;
      head_q         <= '0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      done_cnt_q     <= done_cnt_d;
      err_oob_q      <= err_oob_d;
      pix_ready_q    <= pix_ready_d;
      master_write_q <= master_write_d;
      head_q         <= head_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
    end
  end

`ifdef JULIA_PIXWR_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count cycles where the slave stalls a pending write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                stall_q <= '0;
    else if (start_clr)                          stall_q <= '0;
    else if (master_write_q && master_waitrequest) stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

  assign pix_ready        = pix_ready_q;
  assign master_write     = master_write_q;
  assign master_address   = head_q[ENTW-1:32];
  assign master_writedata = head_q[31:0];
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;
  assign err_oob          = err_oob_q;

endmodule

// File: tb/tb_julia_pixel_writer.sv
// Bench for julia_pixel_writer: full-size instance for mapping/stall/reset,
// small-frame instance for whole-frame completion.
module tb_julia_pixel_writer;
  localparam int unsigned ADDRW = 26;
  localparam int SH = 8;
  localparam int SV = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic a_start = 0, a_valid = 0, a_ready, a_mw, a_wait, a_busy, a_done, a_oob;
  logic [9:0] a_x = '0;
  logic [8:0] a_y = '0;
  logic [7:0] a_iter = '0;
  logic [ADDRW-1:0] a_addr;
  logic [31:0] a_data, a_stall;

  logic b_start = 0, b_valid = 0, b_ready, b_mw, b_wait, b_busy, b_done, b_oob;
  logic [9:0] b_x = '0;
  logic [8:0] b_y = '0;
  logic [7:0] b_iter = '0;
  logic [ADDRW-1:0] b_addr;
  logic [31:0] b_data, b_stall;

  logic a_hold = 0, a_rnd = 0, b_rnd = 0, mon_en = 0;
  int n_checks = 0, n_fail = 0;
  int a_stall_exp = 0, b_writes = 0, b_pulses = 0;
  logic b_done_prev = 0;
  logic [57:0] qa[$];
  logic [57:0] qb[$];

  julia_pixel_writer dut_a (
    .clk(clk), .reset_n(reset_n), .start_frame(a_start), .pix_valid(a_valid),
    .pix_ready(a_ready), .pix_x(a_x), .pix_y(a_y), .pix_iter(a_iter),
    .master_address(a_addr), .master_writedata(a_data), .master_write(a_mw),
    .master_waitrequest(a_wait), .busy(a_busy), .frame_done(a_done),
    .err_oob(a_oob), .stall_cycles(a_stall));

  julia_pixel_writer #(.H_RES(SH), .V_RES(SV)) dut_b (
    .clk(clk), .reset_n(reset_n), .start_frame(b_start), .pix_valid(b_valid),
    .pix_ready(b_ready), .pix_x(b_x), .pix_y(b_y), .pix_iter(b_iter),
    .master_address(b_addr), .master_writedata(b_data), .master_write(b_mw),
    .master_waitrequest(b_wait), .busy(b_busy), .frame_done(b_done),
    .err_oob(b_oob), .stall_cycles(b_stall));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: linear pixel index to byte address, grey = iter replicated into 3 bytes
  function automatic logic [57:0] ref_entry(input int h, input int x, input int y, input int it);
    longint unsigned a;
    logic [31:0] col;
    a   = (64'h0800_0000 + 64'(4 * (y * h + x))) % 64'd67108864;
    col = (it == 255) ? 32'h0 : 32'(it) * 32'h0001_0101;
    return {26'(a), col};
  endfunction

  // Waitrequest drivers
  always @(posedge clk) begin
    #1;
    a_wait = a_rnd ? ($urandom_range(0, 2) == 0) : a_hold;
    b_wait = b_rnd ? ($urandom_range(0, 1) == 0) : 1'b0;
  end

  // Scoreboard for the full-size instance
  always @(negedge clk) begin
    if (!mon_en) begin
      qa.delete();
    end else begin
      check("a_write", a_mw, qa.size() != 0);
      if (a_mw && qa.size() != 0) begin
        check("a_addr", a_addr, qa[0][57:32]);
        check("a_data", a_data, qa[0][31:0]);
      end
      if (a_mw && a_wait) a_stall_exp++;
      if (a_mw && !a_wait && qa.size() != 0) void'(qa.pop_front());
      if (a_valid && a_ready && a_x < 640 && a_y < 480)
        qa.push_back(ref_entry(640, int'(a_x), int'(a_y), int'(a_iter)));
    end
  end

  // Scoreboard and frame tracker for the small instance
  always @(negedge clk) begin
    if (!mon_en) begin
      qb.delete();
    end else begin
      check("b_write", b_mw, qb.size() != 0);
      if (b_mw && qb.size() != 0) begin
        check("b_addr", b_addr, qb[0][57:32]);
        check("b_data", b_data, qb[0][31:0]);
      end
      if (b_done) begin
        check("b_done_after_all_writes", b_writes, SH * SV);
        b_pulses++;
      end
      if (b_done_prev) check("b_busy_after_done", b_busy, 0);
      b_done_prev = b_done;
      if (b_mw && !b_wait && qb.size() != 0) begin
        void'(qb.pop_front());
        b_writes++;
      end
      if (b_valid && b_ready && b_x < SH && b_y < SV)
        qb.push_back(ref_entry(SH, int'(b_x), int'(b_y), int'(b_iter)));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input bit sel);
    if (sel) b_start = 1; else a_start = 1;
    @(posedge clk); #1;
    b_start = 0; a_start = 0;
  endtask

  task automatic send(input bit sel, input int x, input int y, input int it);
    int t = 0;
    if (sel) begin
      b_valid = 1; b_x = 10'(x); b_y = 9'(y); b_iter = 8'(it);
    end else begin
      a_valid = 1; a_x = 10'(x); a_y = 9'(y); a_iter = 8'(it);
    end
    forever begin
      @(negedge clk);
      if (sel ? b_ready : a_ready) break;
      t++;
      if (t > 1000) begin check("send_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    if (sel) b_valid = 0; else a_valid = 0;
  endtask

  task automatic drain_a();
    int t = 0;
    while ((qa.size() != 0 || a_mw) && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    check("a_drain_timeout", t < 3000, 1);
  endtask

  task automatic rand_a_pixel();
    a_x = 10'($urandom_range(0, 639));
    a_y = 9'($urandom_range(0, 479));
    a_iter = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int acc;
    int t;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", a_ready, 0);
    check("rst_write", a_mw, 0);
    check("rst_addr", a_addr, 0);
    check("rst_data", a_data, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_oob", a_oob, 0);
    check("rst_stall", a_stall, 0);
    reset_n = 1; mon_en = 1;
    idle(2);

    start(0);
    check("a_busy_run", a_busy, 1);
    check("a_ready_run", a_ready, 1);

    // In-set pixel at origin
    send(0, 0, 0, 255);
    check("p0_write", a_mw, 1);
    check("p0_addr", a_addr, 26'h0);
    check("p0_data", a_data, 32'h0);
    idle(1);
    check("p0_one_write", a_mw, 0);

    // Last pixel of the frame
    send(0, 639, 479, 8'h40);
    check("plast_addr", a_addr, 26'h12BFFC);
    check("plast_data", a_data, 32'h0040_4040);
    drain_a();

    // Backpressure: FIFO fills and holds its head stable
    a_hold = 1;
    idle(2);
    acc = 0;
    rand_a_pixel();
    a_valid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_ready) acc++;
      @(posedge clk); #1;
      rand_a_pixel();
    end
    a_valid = 0;
    check("full_accepts", acc, 8);
    check("full_ready_low", a_ready, 0);
    a_hold = 0;
    drain_a();
`ifdef JULIA_PIXWR_STALL_CNT_EN
    check("stall_cycles", a_stall, 32'(a_stall_exp));
`else
    check("stall_cycles_tied", a_stall, 0);
`endif

    // Out-of-range pixel is dropped and flagged
    check("oob_clear", a_oob, 0);
    send(0, 640, 0, 7);
    idle(2);
    check("oob_set", a_oob, 1);
    check("oob_no_write", a_mw, 0);

    // Whole frame on the small instance with random stalls and stray pixels
    b_rnd = 1;
    start(1);
    for (int y = 0; y < SV; y++) begin
      for (int x = 0; x < SH; x++) begin
        send(1, x, y, $urandom_range(0, 255));
        idle($urandom_range(0, 2));
        if (y * SH + x == 10) send(1, SH, 1, 3);
        if (y * SH + x == 20) send(1, 3, SV, 3);
      end
    end
    t = 0;
    while (b_pulses == 0 && t < 1000) begin @(posedge clk); #1; t++; end
    check("frame_done_timeout", t < 1000, 1);
    idle(3);
    check("frame_writes", b_writes, SH * SV);
    check("frame_pulses", b_pulses, 1);
    check("frame_busy_after", b_busy, 0);
    check("frame_oob", b_oob, 1);
    b_rnd = 0;

    // Random traffic on the full-size instance
    a_rnd = 1;
    for (int i = 0; i < 150; i++) begin
      send(0, $urandom_range(0, 639), $urandom_range(0, 479),
           ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 254));
      idle($urandom_range(0, 1));
    end
    a_rnd = 0;
    drain_a();

    // Reset with queued entries
    a_hold = 1;
    idle(2);
    for (int i = 0; i < 5; i++) send(0, i, i, 16 + i);
    #2;
    mon_en = 0;
    reset_n = 0;
    #1;
    check("rst_mid_write", a_mw, 0);
    check("rst_mid_busy", a_busy, 0);
    check("rst_mid_ready", a_ready, 0);
    @(posedge clk); #1;
    reset_n = 1;
    a_hold = 0;
    mon_en = 1;
    idle(3);
    check("post_rst_idle", a_busy, 0);
    check("post_rst_empty", a_mw, 0);
    check("post_rst_ready", a_ready, 0);
    start(0);
    send(0, 5, 7, 9);
    check("post_rst_addr", a_addr, 26'h4614);
    check("post_rst_data", a_data, 32'h0009_0909);
    drain_a();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
